// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Raster timing bundle between the VGA timing generator and
//                its consumers (pixel generators, display pins).
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
   parameter int CW = 10,
   parameter int FW = 16
);
   logic          en;
   logic          p_tick;
   logic [CW-1:0] pixel_x;
   logic [CW-1:0] pixel_y;
   logic          hsync;
   logic          vsync;
   logic          video_on;
   logic          line_end;
   logic          frame_end;
   logic [FW-1:0] frame_cnt;

   modport master (
      input  en,
      output p_tick, pixel_x, pixel_y, hsync, vsync, video_on,
             line_end, frame_end, frame_cnt
   );

   modport slave (
      output en,
      input  p_tick, pixel_x, pixel_y, hsync, vsync, video_on,
             line_end, frame_end, frame_cnt
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA raster timing generator with pixel-clock
//                divider, run/freeze enable, line/frame strobes and a
//                completed-frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int H_DISP = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_DISP = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int DIV    = 4,
   parameter int HS_ACT = 1,
   parameter int VS_ACT = 1,
   parameter int CW     = 10,
   parameter int FW     = 16
) (
   input  wire logic         clk,
   input  wire logic         reset,
   vga_timing_gen_if.master  bus
);
   localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] c_DIV_LAST = DW'(DIV - 1);
   localparam logic [CW-1:0] c_H_LAST   = CW'(H_TOT - 1);
   localparam logic [CW-1:0] c_V_LAST   = CW'(V_TOT - 1);
   localparam int            c_HS_BEG   = H_DISP + H_FP;
   localparam int            c_HS_END   = H_DISP + H_FP + H_SYNC - 1;
   localparam int            c_VS_BEG   = V_DISP + V_FP;
   localparam int            c_VS_END   = V_DISP + V_FP + V_SYNC - 1;
   localparam logic          c_HS_ON    = HS_ACT[0];
   localparam logic          c_VS_ON    = VS_ACT[0];

   // Reject geometries the counters cannot represent.
   generate
      if (DIV < 1) begin : g_bad_div
         $error("vga_timing_gen: DIV must be at least 1");
      end
      if (H_TOT > (2 ** CW)) begin : g_bad_htot
         $error("vga_timing_gen: H_TOT does not fit in CW bits");
      end
      if (V_TOT > (2 ** CW)) begin : g_bad_vtot
         $error("vga_timing_gen: V_TOT does not fit in CW bits");
      end
   endgenerate

   logic [DW-1:0] r_div;
   logic [CW-1:0] r_x;
   logic [CW-1:0] r_y;
   logic          r_hs;
   logic          r_vs;
   logic          r_vid;
   logic [FW-1:0] r_fcnt;

   logic          w_tick;
   logic          w_line_end;
   logic          w_frame_end;
   logic [CW-1:0] w_x_nxt;
   logic [CW-1:0] w_y_nxt;
   logic [31:0]   w_x_ext;
   logic [31:0]   w_y_ext;

   // Strobes are masked while reset is held so DIV=1 cannot tick in reset.
   assign w_tick      = bus.en & ~reset & (r_div == c_DIV_LAST);
   assign w_line_end  = w_tick & (r_x == c_H_LAST);
   assign w_frame_end = w_line_end & (r_y == c_V_LAST);

   // Next raster position; sync/video are registered from this so they
   // line up with pixel_x/pixel_y in the same cycle.
   always_comb begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
      if (w_tick) begin
         w_x_nxt = (r_x == c_H_LAST) ? '0 : r_x + CW'(1);
      end
      if (w_line_end) begin
         w_y_nxt = (r_y == c_V_LAST) ? '0 : r_y + CW'(1);
      end
      w_x_ext = 32'(w_x_nxt);
      w_y_ext = 32'(w_y_nxt);
   end

   // Pixel-clock divider, advancing only while enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div <= '0;
      end else if (bus.en) begin
         r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + DW'(1);
      end
   end

   // Raster position, sync/video outputs and frame counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x    <= '0;
         r_y    <= '0;
         r_hs   <= ~c_HS_ON;
         r_vs   <= ~c_VS_ON;
         r_vid  <= 1'b1;
         r_fcnt <= '0;
      end else begin
         r_x   <= w_x_nxt;
         r_y   <= w_y_nxt;
         r_hs  <= ((w_x_ext >= 32'(c_HS_BEG)) && (w_x_ext <= 32'(c_HS_END)))
                  ? c_HS_ON : ~c_HS_ON;
         r_vs  <= ((w_y_ext >= 32'(c_VS_BEG)) && (w_y_ext <= 32'(c_VS_END)))
                  ? c_VS_ON : ~c_VS_ON;
         r_vid <= (w_x_ext < 32'(H_DISP)) && (w_y_ext < 32'(V_DISP));
         if (w_frame_end) begin
            r_fcnt <= r_fcnt + FW'(1);
         end
      end
   end

   assign bus.p_tick    = w_tick;
   assign bus.pixel_x   = r_x;
   assign bus.pixel_y   = r_y;
   assign bus.hsync     = r_hs;
   assign bus.vsync     = r_vs;
   assign bus.video_on  = r_vid;
   assign bus.line_end  = w_line_end;
   assign bus.frame_end = w_frame_end;
   assign bus.frame_cnt = r_fcnt;
endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, successor to the fixed 640x480 sync block. Geometry, pixel-clock divide ratio and sync polarities are set by parameters. Adds a run/freeze enable, line/frame end strobes and a frame counter. It drives the pixel generators (paddle, ball, text) and the display pins.

## Interface
Parameters:
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels after display, before hsync)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (after hsync, before next line)
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- DIV, 4, clk cycles per pixel (≥1)
- HS_ACT, 1, active level of hsync
- VS_ACT, 1, active level of vsync
- CW, 10, pixel_x/pixel_y width
- FW, 16, frame counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  run enable; low freezes all state
- p_tick  out  1  pixel enable strobe, one clk wide
- pixel_x  out  CW  current column, 0..H_TOT-1
- pixel_y  out  CW  current row, 0..V_TOT-1
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- video_on  out  1  registered; high when pixel_x<H_DISP and pixel_y<V_DISP
- line_end  out  1  strobe on the p_tick that ends a line
- frame_end  out  1  strobe on the p_tick that ends a frame
- frame_cnt  out  FW  completed-frame count, wraps

## Operation
- H_TOT = H_DISP+H_FP+H_SYNC+H_BP; V_TOT = V_DISP+V_FP+V_SYNC+V_BP.
- Elaboration must fail if DIV<1, H_TOT>2^CW or V_TOT>2^CW.
- The divider counter runs 0..DIV-1 and advances only while en=1.
- p_tick = en & (div_cnt==DIV-1). It is combinational from registers. With DIV=1, p_tick=en.
- Horizontal counter: on p_tick, increments; at H_TOT-1 it wraps to 0.
- Vertical counter: advances only on p_tick & h==H_TOT-1; at V_TOT-1 it wraps to 0.
- line_end = p_tick & (h==H_TOT-1).
- frame_end = line_end & (v==V_TOT-1).
- frame_cnt increments on frame_end and wraps from 2^FW-1 to 0.
- hsync equals HS_ACT when H_DISP+H_FP ≤ h ≤ H_DISP+H_FP+H_SYNC-1, else ~HS_ACT.
- vsync equals VS_ACT when V_DISP+V_FP ≤ v ≤ V_DISP+V_FP+V_SYNC-1, else ~VS_ACT.
- hsync, vsync and video_on are registered from the next-state counter values. They are therefore glitch-free and always correspond to the pixel_x/pixel_y presented in the same cycle, with no skew.
- en=0: divider, counters, sync/video registers and frame_cnt all hold. p_tick, line_end and frame_end are 0. Resuming continues exactly where the generator stopped.

## Timing
- Reset values (asynchronous, immediate, also mid-frame):
  - div_cnt=0, pixel_x=0, pixel_y=0, frame_cnt=0
  - hsync=~HS_ACT, vsync=~VS_ACT
  - video_on=1 (position 0,0 is visible)
  - p_tick=0 while reset is asserted
- First p_tick is high in the DIV-th clk cycle after reset release, given en=1 throughout. Period is then DIV clks.
- Counters and registered outputs update on the clk edge that ends a p_tick cycle.
- Latency from position to sync/video: 0 cycles, by construction.
- Line period is H_TOT·DIV clks; frame period is V_TOT·H_TOT·DIV clks.
- Simultaneous line and frame wrap: both counters reach 0 on the same edge. frame_end and line_end are high in the same cycle.

## Test plan
- Defaults, en=1: p_tick has period 4. line_end occurs every 3200 clks. frame_end first occurs at clk 1,680,000. frame_cnt=1 afterwards.
- Defaults, hsync: hsync=1 exactly for x=656..751 and 0 at x=655 and x=752. vsync=1 only for y=490..491. video_on=1 for x<640, y<480 only.
- Polarity: HS_ACT=0, VS_ACT=0, DIV=1. Both syncs reset to 1. hsync is low for 96 consecutive clks per 800-clk line.
- Freeze: drop en at x=300. pixel_x stays 300 for 50 clks with no strobes. After en returns, x reaches 301 after the remaining divider cycles.
- Async reset asserted mid-frame (x=700, y=491, between clk edges): pixel_x/pixel_y, frame_cnt and syncs immediately return to their reset values, including hsync/vsync inactive.
- Wraps: FW=2, run 4 frames → frame_cnt goes 1,2,3,0. At the last pixel, line_end and frame_end are both high, then x=y=0 on the next edge.
